dmem_dump_reader: RTL
=====================

# dmem_dump_reader

Data-memory block for the single-cycle CPU with a built-in hardware read-out engine. It serves the CPU's store path (`address_to_mem`, `data_to_mem`, `write_enable`) and its combinational load path like the existing data RAM. On request, it reads the whole RAM back out over a valid/ready stream, one word at a time, so post-run memory contents can be collected in hardware. It replaces the data memory instance inside `top` and exposes the dump stream at the system boundary.

## Interface
- `DEPTH`, 64, number of 32-bit words; power of two, 4..1024
- `AW`, 6, word-index width; must equal log2(DEPTH)
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low; 0 = in reset
- `address_to_mem`  in  32  CPU byte address; word index = `address_to_mem[AW+1:2]`
- `data_to_mem`  in  32  CPU store data
- `write_enable`  in  1  CPU store strobe, sampled at the rising edge
- `read_data`  out  32  combinational `RAM[address_to_mem[AW+1:2]]`
- `dump_start`  in  1  request a full dump; sampled only in IDLE
- `dump_data`  out  32  current dump word (registered)
- `dump_addr`  out  AW  word index of `dump_data`
- `dump_valid`  out  1  `dump_data`/`dump_addr` are valid
- `dump_ready`  in  1  consumer accepts the word when high together with `dump_valid`
- `dump_busy`  out  1  high in LOAD, SEND and DONE
- `dump_done`  out  1  single-cycle pulse after the last word is accepted

## Operation
- RAM: DEPTH x 32. It is not cleared by reset; its contents survive reset.
- CPU write: on the rising edge with `write_enable`=1, `RAM[idx] <= data_to_mem`. Address bits `[1:0]` and `[31:AW+2]` are ignored, so higher addresses alias (wrap).
- CPU read is purely combinational and is unaffected by dump activity.
- Dump FSM, with pointer `ptr` (AW bits):
  - **IDLE**: `dump_start`=1 sets `ptr<=0` and moves to LOAD.
  - **LOAD**: loads `dump_data<=RAM[ptr]` and `dump_addr<=ptr`, then moves to SEND.
  - **SEND**: `dump_valid`=1.
    - If `dump_ready`=1 and `ptr`=DEPTH-1, move to DONE.
    - If `dump_ready`=1 otherwise, `ptr<=ptr+1` and move to LOAD.
    - If `dump_ready`=0, hold.
  - **DONE**: `dump_done`=1 for this cycle, then move to IDLE.
- `dump_start` outside IDLE is ignored; there is no queuing.
- While SEND is stalled, `dump_data` and `dump_addr` stay stable.
- Concurrent CPU writes are allowed during a dump:
  - A word written before its LOAD edge is dumped with the new value.
  - A same-edge write to the word being loaded dumps the OLD value (read-before-write).
  - A write to an already-sent word is not re-sent.
- Reset mid-dump aborts immediately:
  - The FSM goes to IDLE and all dump outputs take their reset values.
  - No `dump_done` pulse is produced.
  - RAM keeps any writes already completed.

## Timing
- Reset values: `dump_valid`=0, `dump_busy`=0, `dump_done`=0, `dump_data`=0, `dump_addr`=0, FSM=IDLE, `ptr`=0.
- `dump_start` sampled at edge E0 puts the FSM in LOAD. At E1 the first word is loaded, and `dump_valid` rises after E1.
- Each accepted word costs 2 cycles minimum (SEND accept, then LOAD). With `dump_ready` tied high, word k is valid in cycle 2k+2 after E0.
- The last word is accepted at edge E(2·DEPTH). `dump_done` is high for the following cycle, and `dump_busy` falls after it.
- The full dump takes a minimum of 2·DEPTH+1 cycles from E0 back to IDLE.
- `read_data` has zero latency.
- A CPU write at edge E is visible on `read_data` immediately after E.

## Test plan
- **Reset and writes:** after reset release, write 0x11111111·i to byte address 4·i for i=0..63, then start a dump with `dump_ready`=1. Expect 64 beats, each `dump_addr`=i and `dump_data`=0x11111111·i, followed by one `dump_done` pulse. The dump takes 129 cycles from start to IDLE.
- **Backpressure:** toggle `dump_ready` pseudo-randomly. Expect no beat lost or duplicated, and `dump_data`/`dump_addr` stable on every stalled cycle.
- **Aliasing:** write 0xDEADBEEF to address 0x100. Expect `read_data` at address 0x000 = 0xDEADBEEF, and dump word 0 = 0xDEADBEEF.
- **Concurrent write:**
  - Mid-dump, write 0xAAAA5555 to an index not yet sent: the dump shows the new value.
  - Write 0x5555AAAA to an index already sent: the dump shows the old value.
  - Write on the exact LOAD edge of index j: the dump shows the old value.
- **Start in progress, then reset:** pulse `dump_start` while busy; the sequence is unaffected and there is no second dump. Assert `reset`=0 during word 10. Expect `dump_valid`, `dump_busy` and `dump_done` to be 0 immediately, with no done pulse. RAM keeps its contents, and a new dump restarts from address 0.

Source files
------------

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: DEPTH x 32 data RAM for the single-cycle CPU.
// It also has a read-out engine that streams the whole RAM over valid/ready.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset (RAM is not cleared)
//   address_to_mem        CPU byte address; word index = address_to_mem[AW+1:2]
//   data_to_mem           CPU store data
//   write_enable          CPU store strobe
//   read_data             combinational load data for address_to_mem
//   dump_start            request a full dump (only honoured while idle)
//   dump_data, dump_addr  current dump word and its word index (registered)
//   dump_valid            dump_data/dump_addr valid
//   dump_ready            consumer accepts the word when high with dump_valid
//   dump_busy             dump in progress (LOAD, SEND, DONE)
//   dump_done             one-cycle pulse after the last word is accepted
module dmem_dump_reader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address_to_mem,
  input  logic [31:0]   data_to_mem,
  input  logic          write_enable,
  output logic [31:0]   read_data,
  input  logic          dump_start,
  output logic [31:0]   dump_data,
  output logic [AW-1:0] dump_addr,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          dump_busy,
  output logic          dump_done
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          load_en;

  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] cpu_idx;
  logic          unused_addr_bits;

  // Upper and sub-word address bits are ignored, so addresses alias.
  assign cpu_idx          = address_to_mem[AW+1:2];
  assign unused_addr_bits = ^{address_to_mem[31:AW+2], address_to_mem[1:0]};

  // CPU load path: zero-latency read.
  assign read_data = ram[cpu_idx];

  // CPU store path; the RAM has no reset, so contents survive reset.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      ram[cpu_idx] <= data_to_mem;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state logic for the dump engine.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          ptr_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          if (ptr == AW'(DEPTH - 1)) begin
            state_next = DONE;
          end else begin
            ptr_next   = ptr + AW'(1);
            state_next = LOAD;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered dump outputs. Flags are decoded from the next state so they
  // line up with the state they describe. The LOAD read samples the RAM
  // before a same-edge CPU write lands (read-before-write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      if (load_en) begin
        dump_data <= ram[ptr];
        dump_addr <= ptr;
      end
      dump_valid <= (state_next == SEND);
      dump_busy  <= (state_next != IDLE);
      dump_done  <= (state_next == DONE);
    end
  end

endmodule
